// File: rtl/truth_table_checker.sv
// truth_table_checker
// Self-running sweeper for 3-input logic exercises. It drives every input
// vector onto the shared abc bus and holds each one for SETTLE cycles. It then
// samples the SOP, POS and reduced outputs, captures the SOP truth table and
// records any vector where the three implementations disagree.
//
// Handshake: start is a level request, accepted on any rising edge where the
// FSM is in IDLE or DONE with start high. It is ignored while busy. busy
// covers the whole sweep. done marks stable results until the next accepted
// start or reset.
module truth_table_checker #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 y_sop,
   input  logic                 y_pos,
   input  logic                 y_red,
   output logic [N_IN-1:0]      abc,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   table_out,
   output logic                 mismatch,
   output logic [N_IN:0]        err_count,
   output logic [N_IN-1:0]      first_err_idx,
   output logic [1:0]           state_dbg
);

   localparam int NV = 2**N_IN;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
   localparam logic [N_IN-1:0] ABC_LAST = N_IN'(NV - 1);
   localparam logic [N_IN:0]   ERR_MAX  = (N_IN + 1)'(NV);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [CW-1:0]   settle_cnt;
   logic            settle_last;
   logic            last_vec;
   logic            vec_fail;
   logic            accept;

   // Decode the conditions shared by the FSM and the datapath
   always_comb begin
      settle_last = (settle_cnt == CNT_LAST);
      last_vec    = (abc == ABC_LAST);
      vec_fail    = (y_sop != y_pos) || (y_sop != y_red);
   end

   // State register; reset aborts any sweep in progress
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: the sweep walks DRIVE/SAMPLE once per vector
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = DRIVE;
         DRIVE:   if (settle_last) next_state = SAMPLE;
         SAMPLE:  next_state = last_vec ? DONE : DRIVE;
         DONE:    if (start) next_state = DRIVE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode: status flags follow the current state directly
   always_comb begin
      busy      = (state == DRIVE) || (state == SAMPLE);
      done      = (state == DONE);
      accept    = ((state == IDLE) || (state == DONE)) && start;
      state_dbg = state;
   end

   // Datapath: vector counter, settle timer and result capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         abc           <= '0;
         settle_cnt    <= '0;
         table_out     <= '0;
         mismatch      <= 1'b0;
         err_count     <= '0;
         first_err_idx <= '0;
      end else if (accept) begin
         // A new sweep discards the previous results on the accept edge
         abc           <= '0;
         settle_cnt    <= '0;
         table_out     <= '0;
         mismatch      <= 1'b0;
         err_count     <= '0;
         first_err_idx <= '0;
      end else if (state == DRIVE) begin
         if (!settle_last) begin
            settle_cnt <= settle_cnt + CW'(1);
         end
      end else if (state == SAMPLE) begin
         table_out[abc] <= y_sop;
         if (vec_fail) begin
            if (err_count != ERR_MAX) begin
               err_count <= err_count + (N_IN + 1)'(1);
            end
            mismatch <= 1'b1;
            // mismatch is still low only for the first failing vector
            if (!mismatch) begin
               first_err_idx <= abc;
            end
         end
         // The last vector stays on the bus; abc never wraps back to 0
         if (!last_vec) begin
            abc        <= abc + N_IN'(1);
            settle_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker
// Directed and randomized sweeps of truth_table_checker. The bench uses two
// instances: the default SETTLE=1 and a SETTLE=3 variant. The Y inputs come
// from bench-owned 8-entry truth tables indexed by each instance's abc.
// Expected results come from the tables alone.
module tb_truth_table_checker;

   localparam int N_IN = 3;
   localparam int NV   = 2**N_IN;

   logic clk = 1'b0;
   logic rst_n;
   logic start_drv;
   logic s3;

   logic [NV-1:0] tt_sop, tt_pos, tt_red;

   // instance with SETTLE = 1
   logic            start1, y_sop1, y_pos1, y_red1;
   logic [N_IN-1:0] abc1, first1;
   logic            busy1, done1, mm1;
   logic [NV-1:0]   tab1;
   logic [N_IN:0]   err1;
   logic [1:0]      st1;

   // instance with SETTLE = 3
   logic            start3, y_sop3, y_pos3, y_red3;
   logic [N_IN-1:0] abc3, first3;
   logic            busy3, done3, mm3;
   logic [NV-1:0]   tab3;
   logic [N_IN:0]   err3;
   logic [1:0]      st3;

   // view of whichever instance is selected
   logic [N_IN-1:0] m_abc, m_first;
   logic            m_busy, m_done, m_mm;
   logic [NV-1:0]   m_tab;
   logic [N_IN:0]   m_err;

   int checks = 0;
   int errors = 0;

   logic [N_IN-1:0] exp_q[$];

   always #5 clk = ~clk;

   assign start1 = start_drv & ~s3;
   assign start3 = start_drv & s3;
   assign y_sop1 = tt_sop[abc1];
   assign y_pos1 = tt_pos[abc1];
   assign y_red1 = tt_red[abc1];
   assign y_sop3 = tt_sop[abc3];
   assign y_pos3 = tt_pos[abc3];
   assign y_red3 = tt_red[abc3];

   assign m_abc   = s3 ? abc3   : abc1;
   assign m_first = s3 ? first3 : first1;
   assign m_busy  = s3 ? busy3  : busy1;
   assign m_done  = s3 ? done3  : done1;
   assign m_mm    = s3 ? mm3    : mm1;
   assign m_tab   = s3 ? tab3   : tab1;
   assign m_err   = s3 ? err3   : err1;

   truth_table_checker #(.N_IN(N_IN), .SETTLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .y_sop(y_sop1), .y_pos(y_pos1), .y_red(y_red1),
      .abc(abc1), .busy(busy1), .done(done1), .table_out(tab1),
      .mismatch(mm1), .err_count(err1), .first_err_idx(first1),
      .state_dbg(st1)
   );

   truth_table_checker #(.N_IN(N_IN), .SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3),
      .y_sop(y_sop3), .y_pos(y_pos3), .y_red(y_red3),
      .abc(abc3), .busy(busy3), .done(done3), .table_out(tab3),
      .mismatch(mm3), .err_count(err3), .first_err_idx(first3),
      .state_dbg(st3)
   );

   // global time limit
   initial begin
      #2_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "time limit");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: results follow from the three truth tables alone
   task automatic check_results(input string tag);
      logic [NV-1:0] diff;
      int            n_err;
      int            first;
      diff  = (tt_sop ^ tt_pos) | (tt_sop ^ tt_red);
      n_err = 0;
      first = -1;
      for (int i = 0; i < NV; i++) begin
         if (diff[i]) begin
            n_err++;
            if (first < 0) first = i;
         end
      end
      if (first < 0) first = 0;
      chk({tag, "_table"}, 32'(m_tab), 32'(tt_sop));
      chk({tag, "_err"},   32'(m_err), 32'(n_err));
      chk({tag, "_mm"},    32'(m_mm),  32'(n_err != 0));
      chk({tag, "_first"}, 32'(m_first), 32'(first));
   endtask

   task automatic sweep(input bit sel3, input bit mid_pulse, input bit hold_start,
                        input string tag);
      int per;
      int total;
      s3    = sel3;
      per   = sel3 ? 4 : 2;
      total = NV * per;
      exp_q.delete();
      for (int c = 1; c < total; c++) exp_q.push_back(N_IN'(c / per));

      start_drv = 1'b1;
      step();
      if (!hold_start) start_drv = 1'b0;
      // accept edge: results cleared, sweep starts at vector 0
      chk({tag, "_acc_abc"},   32'(m_abc),   0);
      chk({tag, "_acc_busy"},  32'(m_busy),  1);
      chk({tag, "_acc_done"},  32'(m_done),  0);
      chk({tag, "_acc_tab"},   32'(m_tab),   0);
      chk({tag, "_acc_err"},   32'(m_err),   0);
      chk({tag, "_acc_mm"},    32'(m_mm),    0);
      chk({tag, "_acc_first"}, 32'(m_first), 0);

      for (int c = 1; c <= total; c++) begin
         if (mid_pulse) start_drv = (c == 4) ? 1'b1 : (hold_start ? start_drv : 1'b0);
         step();
         if (c < total) begin
            chk({tag, "_abc"},  32'(m_abc),  32'(exp_q.pop_front()));
            chk({tag, "_done"}, 32'(m_done), 0);
         end else begin
            chk({tag, "_end_done"}, 32'(m_done), 1);
            chk({tag, "_end_busy"}, 32'(m_busy), 0);
            chk({tag, "_end_abc"},  32'(m_abc),  NV - 1);
         end
      end
      check_results(tag);
   endtask

   initial begin
      rst_n     = 1'b0;
      start_drv = 1'b0;
      s3        = 1'b0;
      tt_sop    = 8'hE8;
      tt_pos    = 8'hE8;
      tt_red    = 8'hE8;
      step();
      step();
      // reset state of both instances
      chk("rst_abc",   32'(abc1),   0);
      chk("rst_busy",  32'(busy1),  0);
      chk("rst_done",  32'(done1),  0);
      chk("rst_tab",   32'(tab1),   0);
      chk("rst_err",   32'(err1),   0);
      chk("rst_mm",    32'(mm1),    0);
      chk("rst_first", 32'(first1), 0);
      chk("rst3_busy", 32'(busy3),  0);
      chk("rst3_tab",  32'(tab3),   0);
      rst_n = 1'b1;
      step();

      // majority on all three
      sweep(1'b0, 1'b0, 1'b0, "t1");
      chk("t1_table_const", 32'(tab1), 32'h0000_00E8);

      // done holds stable while start stays low
      step();
      step();
      chk("t1_hold_done", 32'(done1), 1);
      check_results("t1_hold");

      // single disagreement at vector 5
      tt_pos = 8'hE8 ^ 8'h20;
      sweep(1'b0, 1'b0, 1'b0, "t2");

      // reduced output stuck at 0
      tt_pos = 8'hE8;
      tt_red = 8'h00;
      sweep(1'b0, 1'b0, 1'b0, "t3");

      // reset in mid-sweep at vector 4
      tt_red    = 8'hE8;
      start_drv = 1'b1;
      step();
      start_drv = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (abc1 == 3'd4) break;
         step();
      end
      chk("t4_reach4", 32'(abc1), 4);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t4_abc",   32'(abc1),   0);
      chk("t4_busy",  32'(busy1),  0);
      chk("t4_done",  32'(done1),  0);
      chk("t4_tab",   32'(tab1),   0);
      chk("t4_err",   32'(err1),   0);
      chk("t4_mm",    32'(mm1),    0);
      chk("t4_first", 32'(first1), 0);
      step();
      chk("t4_idle_busy", 32'(busy1), 0);
      sweep(1'b0, 1'b0, 1'b0, "t4b");

      // start pulse while busy is ignored
      sweep(1'b0, 1'b1, 1'b0, "t5");

      // start held through DONE restarts with cleared results
      tt_pos = 8'hE8 ^ 8'h20;
      sweep(1'b0, 1'b0, 1'b1, "t6a");
      tt_pos = 8'hE8;
      sweep(1'b0, 1'b0, 1'b0, "t6b");

      // SETTLE = 3 instance
      sweep(1'b1, 1'b0, 1'b0, "t7");

      // randomized truth tables with sparse disagreements
      for (int r = 0; r < 8; r++) begin
         tt_sop = NV'($urandom);
         tt_pos = tt_sop ^ (NV'($urandom) & NV'($urandom) & NV'($urandom));
         tt_red = tt_sop ^ (NV'($urandom) & NV'($urandom) & NV'($urandom));
         sweep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
